// File: rtl/uart_adder_requester.sv
// Host-side UART adder requester: sends operands A,B (8N1), receives A,B,sum, checks them.
// Latency: done about 20*CLKS_PER_BIT+2 cycles after start plus reply time; timeout bounded by TIMEOUT_CLKS.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
module uart_adder_requester #(
    parameter int          CLKS_PER_BIT = 1250,
    parameter logic [23:0] TIMEOUT_CLKS = 24'd1200000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       tx,
    input  logic       rx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] err_code,
    output logic [7:0] rsp_a,
    output logic [7:0] rsp_b,
    output logic [7:0] rsp_sum
);

    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_A, S_SEND_B, S_RECV, S_CHECK, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        R_HUNT, R_START, R_DATA, R_STOP
    } rx_phase_t;

    state_t      state;
    rx_phase_t   rx_phase;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [7:0]  sum_exp;
    logic [8:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic [3:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [CW-1:0] clk_cnt;
    logic [23:0] to_cnt;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic        rx_fall;
    logic        mismatch;

    // carry out of the operand sum is intentionally dropped
    assign sum_exp  = a_q + b_q;
    assign rx_fall  = rx_prev & ~rx_s;
    assign mismatch = (rsp_a != a_q) || (rsp_b != b_q) || (rsp_sum != sum_exp);

    // two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // transaction FSM: transmit both frames, receive three bytes, check, report
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rx_phase <= R_HUNT;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            tx_shift <= 9'h1ff;
            rx_shift <= 8'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
            clk_cnt  <= '0;
            to_cnt   <= 24'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= 2'b00;
            rsp_a    <= 8'd0;
            rsp_b    <= 8'd0;
            rsp_sum  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        rsp_a    <= 8'd0;
                        rsp_b    <= 8'd0;
                        rsp_sum  <= 8'd0;
                        pass     <= 1'b0;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        tx_shift <= {1'b1, op_a};
                        bit_idx  <= 4'd0;
                        clk_cnt  <= '0;
                        state    <= S_SEND_A;
                    end
                end
                S_SEND_A, S_SEND_B: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            if (state == S_SEND_A) begin
                                // B starts immediately after A's stop bit
                                tx       <= 1'b0;
                                tx_shift <= {1'b1, b_q};
                                bit_idx  <= 4'd0;
                                state    <= S_SEND_B;
                            end else begin
                                tx       <= 1'b1;
                                rx_phase <= R_HUNT;
                                to_cnt   <= 24'd0;
                                byte_idx <= 2'd0;
                                state    <= S_RECV;
                            end
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_RECV: begin
                    case (rx_phase)
                        R_HUNT: begin
                            if (to_cnt >= TIMEOUT_CLKS - 24'd1) begin
                                err_code <= 2'b11;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                to_cnt <= to_cnt + 24'd1;
                                if (rx_fall) begin
                                    clk_cnt  <= '0;
                                    rx_phase <= R_START;
                                end
                            end
                        end
                        R_START: begin
                            // a rejected glitch must not reset the timeout window
                            to_cnt <= to_cnt + 24'd1;
                            if (clk_cnt == HALF_LAST) begin
                                clk_cnt <= '0;
                                if (rx_s) begin
                                    rx_phase <= R_HUNT;
                                end else begin
                                    bit_idx  <= 4'd0;
                                    rx_phase <= R_DATA;
                                end
                            end else begin
                                clk_cnt <= clk_cnt + 1'b1;
                            end
                        end
                        R_DATA: begin
                            if (clk_cnt == BIT_LAST) begin
                                clk_cnt  <= '0;
                                rx_shift <= {rx_s, rx_shift[7:1]};
                                if (bit_idx == 4'd7) begin
                                    rx_phase <= R_STOP;
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                end
                            end else begin
                                clk_cnt <= clk_cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (clk_cnt == BIT_LAST) begin
                                clk_cnt <= '0;
                                if (!rx_s) begin
                                    err_code <= 2'b10;
                                    busy     <= 1'b0;
                                    done     <= 1'b1;
                                    state    <= S_DONE;
                                end else begin
                                    case (byte_idx)
                                        2'd0:    rsp_a   <= rx_shift;
                                        2'd1:    rsp_b   <= rx_shift;
                                        default: rsp_sum <= rx_shift;
                                    endcase
                                    to_cnt   <= 24'd0;
                                    rx_phase <= R_HUNT;
                                    if (byte_idx == 2'd2) begin
                                        state <= S_CHECK;
                                    end else begin
                                        byte_idx <= byte_idx + 2'd1;
                                    end
                                end
                            end else begin
                                clk_cnt <= clk_cnt + 1'b1;
                            end
                        end
                    endcase
                end
                S_CHECK: begin
                    err_code <= mismatch ? 2'b01 : 2'b00;
                    pass     <= ~mismatch;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_adder_requester.sv
// Bench for uart_adder_requester: random and directed transactions against a reference model.
// Latency: checks timeout timing exactly; other results checked whenever done pulses.
// Backpressure: not applicable; bench drives rx as the remote UART adder.
module tb_uart_adder_requester;

    localparam int CPB = 8;
    localparam int TMO = 400;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a  = 8'd0;
    logic [7:0] op_b  = 8'd0;
    logic       tx;
    logic       rx    = 1'b1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] err_code;
    logic [7:0] rsp_a;
    logic [7:0] rsp_b;
    logic [7:0] rsp_sum;

    uart_adder_requester #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(24'(TMO))
    ) dut (
        .hwclk   (hwclk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .tx      (tx),
        .rx      (rx),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_code(err_code),
        .rsp_a   (rsp_a),
        .rsp_b   (rsp_b),
        .rsp_sum (rsp_sum)
    );

    always #5 hwclk = ~hwclk;

    typedef struct packed {
        logic       pass;
        logic [1:0] err;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rs;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] tx_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int s_cyc = 0;
    int done_cnt = 0;
    int exp_dones = 0;
    int last_done_cyc = 0;

    always @(posedge hwclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Reference model: what the requester should report for a given reply.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] r0, input logic [7:0] r1,
                                   input logic [7:0] r2, input int nrep, input int bad);
        logic [7:0] rep[3];
        logic [7:0] got[3];
        logic [7:0] want_sum;
        res_t res;
        rep[0] = r0; rep[1] = r1; rep[2] = r2;
        got[0] = 8'd0; got[1] = 8'd0; got[2] = 8'd0;
        res.err = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (res.err == 2'b00) begin
                if (i >= nrep) res.err = 2'b11;
                else if (i == bad) res.err = 2'b10;
                else got[i] = rep[i];
            end
        end
        want_sum = 8'((int'(a) + int'(b)) % 256);
        if (res.err == 2'b00)
            res.err = (got[0] == a && got[1] == b && got[2] == want_sum) ? 2'b00 : 2'b01;
        res.pass = (res.err == 2'b00);
        res.ra = got[0]; res.rb = got[1]; res.rs = got[2];
        return res;
    endfunction

    // Result monitor: pops the expected outcome whenever done pulses.
    always @(negedge hwclk) begin
        res_t e;
        if (reset) begin
            exp_q.delete();
        end else if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            chk("busy_at_done", busy, 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pass", pass, e.pass);
                chk("err_code", err_code, e.err);
                chk("rsp_a", rsp_a, e.ra);
                chk("rsp_b", rsp_b, e.rb);
                chk("rsp_sum", rsp_sum, e.rs);
            end
        end
    end

    // tx monitor: decodes 8N1 frames sampling at bit centres.
    int         txm_cnt = -1;
    logic [7:0] txm_byte = 8'd0;
    logic       tx_prev = 1'b1;
    always @(negedge hwclk) begin
        if (reset) begin
            txm_cnt = -1;
            tx_q.delete();
        end else if (txm_cnt < 0) begin
            if (tx_prev && !tx) txm_cnt = 0;
        end else begin
            txm_cnt++;
            if (txm_cnt == CPB / 2) chk("tx_start_bit", tx, 0);
            if (txm_cnt > CPB && txm_cnt < 9 * CPB && (txm_cnt % CPB) == CPB / 2)
                txm_byte = {tx, txm_byte[7:1]};
            if (txm_cnt == 9 * CPB + CPB / 2) begin
                chk("tx_stop_bit", tx, 1);
                if (tx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_unexpected_frame: got %0h expected none", txm_byte);
                end else begin
                    chk("tx_byte", txm_byte, tx_q.pop_front());
                end
                txm_cnt = -1;
            end
        end
        tx_prev = tx;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge hwclk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge hwclk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge hwclk);
        rx = 1'b1;
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                           input int nrep, input int bad, input bit glitch,
                           input bit pokes, input bit done_poke);
        logic [7:0] rep[3];
        int t;
        rep[0] = r0; rep[1] = r1; rep[2] = r2;
        @(negedge hwclk);
        op_a = a; op_b = b; start = 1'b1;
        s_cyc = cyc + 1;
        tx_q.push_back(a);
        tx_q.push_back(b);
        exp_q.push_back(model(a, b, r0, r1, r2, nrep, bad));
        exp_dones++;
        @(negedge hwclk);
        start = 1'b0;
        // stray start pulses with other operands while the frames go out
        while (cyc < s_cyc + 20 * CPB + 4) begin
            if (pokes && (cyc % 37) == 0) begin
                start = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge hwclk);
        end
        start = 1'b0;
        if (glitch) begin
            rx = 1'b0;
            repeat (2) @(negedge hwclk);
            rx = 1'b1;
            repeat (3 * CPB) @(negedge hwclk);
        end
        for (int i = 0; i < nrep && i < 3; i++) begin
            if (i <= bad || bad < 0) begin
                send_byte(rep[i], (i == bad) ? 1'b0 : 1'b1);
                repeat ($urandom_range(0, 10)) @(negedge hwclk);
            end
        end
        t = 0;
        while ((done_cnt != exp_dones || (done_poke && cyc < s_cyc + 20 * CPB + TMO + 4)) && t < 3000) begin
            start = (done_poke && cyc == s_cyc + 20 * CPB + TMO) ? 1'b1 : 1'b0;
            @(negedge hwclk);
            t++;
        end
        start = 1'b0;
        if (t >= 3000) begin
            n_chk++;
            $display("FAIL done_wait: got no done within 3000 cycles expected done");
        end
        repeat (3) @(negedge hwclk);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL global_timeout: got no finish expected finish within 90000 cycles");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] a, b, r0, r1, r2, fl;
        int idx;
        repeat (3) @(negedge hwclk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_err", err_code, 0);
        chk("reset_rsp", {rsp_a, rsp_b, rsp_sum}, 0);
        reset = 1'b0;
        repeat (2) @(negedge hwclk);

        run_txn(8'h12, 8'h34, 8'h12, 8'h34, 8'h46, 3, -1, 0, 1, 0);
        run_txn(8'hF0, 8'h20, 8'hF0, 8'h20, 8'h10, 3, -1, 0, 0, 0);
        run_txn(8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 3, -1, 0, 0, 0);
        // no reply: done exactly TMO cycles after the B stop bit, and a start on the done cycle is ignored
        run_txn(8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 0, -1, 0, 0, 1);
        chk_rng("timeout_latency", last_done_cyc - s_cyc, 20 * CPB + TMO - 1, 20 * CPB + TMO + 1);
        chk("start_on_done_ignored", busy, 0);
        run_txn(8'h3C, 8'hC3, 8'h3C, 8'h00, 8'h00, 1, -1, 0, 0, 0);
        run_txn(8'h77, 8'h11, 8'h77, 8'h11, 8'h88, 3, 0, 0, 0, 0);
        run_txn(8'h9A, 8'hBC, 8'h9A, 8'hBC, 8'h56, 3, -1, 1, 0, 0);

        // reset during data bit 3 of the B frame
        @(negedge hwclk);
        op_a = 8'h5A; op_b = 8'hA5; start = 1'b1;
        s_cyc = cyc + 1;
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hA5);
        @(negedge hwclk);
        start = 1'b0;
        while (cyc < s_cyc + 10 * CPB + 4 * CPB + 2) @(negedge hwclk);
        chk("busy_mid_send", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_busy", busy, 0);
        repeat (3) @(negedge hwclk);
        reset = 1'b0;
        repeat (2) @(negedge hwclk);
        run_txn(8'h12, 8'h34, 8'h12, 8'h34, 8'h46, 3, -1, 0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            r0 = a; r1 = b; r2 = 8'((int'(a) + int'(b)) % 256);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, 2);
                fl = 8'd1 << $urandom_range(0, 7);
                if (idx == 0) r0 = r0 ^ fl;
                else if (idx == 1) r1 = r1 ^ fl;
                else r2 = r2 ^ fl;
            end
            run_txn(a, b, r0, r1, r2, 3, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        chk("done_count", done_cnt, exp_dones);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("tx_queue_empty", tx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
